// File: rtl/arith_pkg.sv
// Shared arithmetic types and default widths for the small arithmetic leaf blocks.
package arith_pkg;

  localparam int unsigned NBITS_DEFAULT = 8;

  typedef logic [7:0] word8_t;

endpackage : arith_pkg

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out to the next bit.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_sub_cell

// File: rtl/comb_arith_8b_sub.sv
// Wrap-around subtractor out = (in0 - in1) mod 2^NBITS built as a ripple-borrow chain.
// clk/reset exist only for integration uniformity; the block holds no state.
module comb_arith_8b_sub
  import arith_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  output logic [NBITS-1:0] out
);

  logic [NBITS:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < NBITS; i++) begin : g_cell
    full_sub_cell u_cell (
      .a    (in0[i]),
      .b    (in1[i]),
      .bin  (borrow[i]),
      .d    (out[i]),
      .bout (borrow[i+1])
    );
  end

  // The final borrow is intentionally discarded, as are the integration-only pins.
  logic unused_ok;
  assign unused_ok = ^{clk, reset, borrow[NBITS]};

endmodule : comb_arith_8b_sub

// File: tb/tb_comb_arith_8b_sub.sv
// Scoreboard bench for comb_arith_8b_sub: driver queues expected results, monitor checks mid-cycle.
module tb_comb_arith_8b_sub;
  import arith_pkg::*;

  typedef struct {
    word8_t exp;
    string  name;
  } sb_entry_t;

  logic   clk;
  logic   reset;
  word8_t in0;
  word8_t in1;
  word8_t out;

  sb_entry_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  comb_arith_8b_sub #(.NBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair just after the rising edge and queue its expected result.
  task automatic apply(input word8_t a, input word8_t b, input word8_t exp, input string name);
    sb_entry_t e;
    @(posedge clk);
    #1;
    in0 = a;
    in1 = b;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: the output is valid every cycle, so check one queued entry per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      checks++;
      if (out !== e.exp) begin
        errors++;
        $display("FAIL %s: in0=0x%02h in1=0x%02h got 0x%02h expected 0x%02h",
                 e.name, in0, in1, out, e.exp);
      end
    end
  end

  initial begin
    word8_t ra;
    word8_t rb;
    int     budget;
    reset = 1'b1;
    in0   = 8'h00;
    in1   = 8'h00;
    void'($urandom(32'd20240611));

    // Reset asserted from time zero; output must already follow the inputs.
    apply(8'd42, 8'd13, 8'h1D, "reset_hold_0");
    apply(8'd42, 8'd13, 8'h1D, "reset_hold_1");
    apply(8'd42, 8'd13, 8'h1D, "reset_hold_2");
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(8'd42, 8'd13, 8'h1D, "reset_release_0");
    apply(8'd42, 8'd13, 8'h1D, "reset_release_1");

    // Basic positive operands
    apply(8'd0,   8'd0,   8'h00, "pos_0_0");
    apply(8'd42,  8'd13,  8'h1D, "pos_42_13");
    apply(8'd13,  8'd42,  8'hE3, "pos_13_42");
    apply(8'd127, 8'd0,   8'h7F, "pos_127_0");
    apply(8'd0,   8'd128, 8'h80, "pos_0_128");

    // Negative operands (two's-complement patterns)
    apply(8'h00, 8'hFF, 8'h01, "neg_0_m1");
    apply(8'hFF, 8'h00, 8'hFF, "neg_m1_0");
    apply(8'd42, 8'hF3, 8'h37, "neg_42_m13");
    apply(8'hD6, 8'd13, 8'hC9, "neg_m42_13");
    apply(8'hD6, 8'hF3, 8'hE3, "neg_m42_m13");

    // Signed overflow, negative side
    apply(8'h80, 8'd1,  8'h7F, "ovf_m128_1");
    apply(8'h81, 8'd2,  8'h7F, "ovf_m127_2");
    apply(8'h88, 8'd13, 8'h7B, "ovf_m120_13");

    // Signed overflow, positive side
    apply(8'd127, 8'hFF, 8'h80, "ovf_127_m1");
    apply(8'd126, 8'hFE, 8'h80, "ovf_126_m2");
    apply(8'd120, 8'hF3, 8'h85, "ovf_120_m13");

    // Reset pulsed mid-operation must not disturb the result
    reset = 1'b1;
    apply(8'd42, 8'd13, 8'h1D, "reset_mid_0");
    apply(8'd42, 8'd13, 8'h1D, "reset_mid_1");
    reset = 1'b0;
    apply(8'd42, 8'd13, 8'h1D, "reset_mid_2");

    // Seeded random pairs
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      apply(ra, rb, 8'((9'(ra) - 9'(rb)) & 9'h0FF), "random");
    end

    // Let the monitor drain the scoreboard, bounded
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left unchecked, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_comb_arith_8b_sub
